// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX-stage operand forwarding selects and load-use stall
// for the 5-stage pipeline.
//
// The block keeps its own shadow copy of the in-flight destination info
// (EX, MEM and WB slots), so it needs only the ID-stage decode fields and
// the branch flush.
//
// Forward select encoding: 00 register file, 01 MEM/WB, 10 EX/MEM.
// Code 11 is never driven.
//
// Optional feature: define FWD_STALL_CNT_EN to build a saturating stall-cycle
// counter on stall_cnt_o. Without it, stall_cnt_o is tied to zero.
//
// fwd_a_o, fwd_b_o and stall_o are combinational from the slot state and the
// ID inputs. They feed the forwarding muxes and the hazard hold logic in the
// same cycle.

module fwd_hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Full decode info is needed only while the instruction sits in EX.
    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } ex_slot_t;

    // MEM and WB only matter as potential producers.
    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
    } wr_slot_t;

    ex_slot_t ex_q;
    wr_slot_t mem_q;
    wr_slot_t wb_q;

    logic mem_writer;
    logic wb_writer;
    logic ex_load_rd;

    // Shadow pipeline advance; a stall or a flush turns the EX entry into a bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q         <= mem_q;
            mem_q.vld    <= ex_q.vld;
            mem_q.rd     <= ex_q.rd;
            mem_q.regwrite <= ex_q.regwrite;
            ex_q.vld      <= id_valid_i & ~stall_o & ~flush_i;
            ex_q.rs       <= id_rs_i;
            ex_q.rt       <= id_rt_i;
            ex_q.rd       <= id_rd_i;
            ex_q.regwrite <= id_regwrite_i;
            ex_q.memread  <= id_memread_i;
        end
    end

    // Producer qualifiers; register 0 is never a forwarding source.
    always_comb begin
        mem_writer = mem_q.vld & mem_q.regwrite & (mem_q.rd != '0);
        wb_writer  = wb_q.vld  & wb_q.regwrite  & (wb_q.rd  != '0);
        ex_load_rd = ex_q.vld  & ex_q.memread   & (ex_q.rd  != '0);
    end

    // Forward selects: the younger EX/MEM value wins over MEM/WB.
    always_comb begin
        fwd_a_o = FWD_RF;
        fwd_b_o = FWD_RF;
        if (ex_q.vld) begin
            if (mem_writer && (mem_q.rd == ex_q.rs)) begin
                fwd_a_o = FWD_MEM;
            end else if (wb_writer && (wb_q.rd == ex_q.rs)) begin
                fwd_a_o = FWD_WB;
            end

            if (mem_writer && (mem_q.rd == ex_q.rt)) begin
                fwd_b_o = FWD_MEM;
            end else if (wb_writer && (wb_q.rd == ex_q.rt)) begin
                fwd_b_o = FWD_WB;
            end
        end
    end

    // Load-use hazard: the load in EX produces a register the ID instruction reads.
    always_comb begin
        stall_o = id_valid_i & ex_load_rd &
                  ((ex_q.rd == id_rs_i) | (ex_q.rd == id_rt_i));
    end

`ifdef FWD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating count of stall cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed pipeline scenarios followed
// by random instruction streams, checked against an instruction-history model.
module tb_fwd_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs_i;
    logic [4:0]  id_rt_i;
    logic [4:0]  id_rd_i;
    logic        id_regwrite_i;
    logic        id_memread_i;
    logic        flush_i;
    logic        stall_o;
    logic [1:0]  fwd_a_o;
    logic [1:0]  fwd_b_o;
    logic [31:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       vld;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } ins_t;

    localparam ins_t NOP = '0;

    // Instructions that entered EX, oldest first; the last entry is in EX now.
    ins_t        hist[$];
    logic [31:0] cnt_model;

    fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .id_valid_i    (id_valid_i),
        .id_rs_i       (id_rs_i),
        .id_rt_i       (id_rt_i),
        .id_rd_i       (id_rd_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic ins_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic rw, input logic mr);
        ins_t r;
        r.vld = 1'b1; r.rs = rs; r.rt = rt; r.rd = rd; r.rw = rw; r.mr = mr;
        return r;
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int k = 0; k < 3; k++) hist.push_back(NOP);
        cnt_model = 32'd0;
    endfunction

    // True when p is a real instruction that produces register r (r0 never counts).
    function automatic logic produces(input ins_t p, input logic [4:0] r);
        return p.vld && p.rw && (p.rd != 5'd0) && (p.rd == r);
    endfunction

    // Search older instructions, youngest first, for the producer of r.
    function automatic logic [1:0] source_of(input logic [4:0] r);
        int n = hist.size();
        if (!hist[n-1].vld) return 2'b00;
        for (int age = 1; age <= 2; age++) begin
            if (produces(hist[n-1-age], r)) return (age == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic needs_stall(input ins_t d);
        ins_t c = hist[hist.size()-1];
        return d.vld && c.vld && c.mr && (c.rd != 5'd0) &&
               ((c.rd == d.rs) || (c.rd == d.rt));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle with instruction i in ID. The model is always checked; when
    // use_k is set, the fixed scenario values k_* are checked as well.
    task automatic step(input ins_t i, input logic fl, input logic rs, input string tag,
                        input logic use_k, input logic k_st,
                        input logic [1:0] k_fa, input logic [1:0] k_fb,
                        output logic st_out);
        logic        e_st;
        logic [1:0]  e_fa, e_fb;
        logic [31:0] e_cnt;
        ins_t        c;
        id_valid_i = i.vld; id_rs_i = i.rs; id_rt_i = i.rt; id_rd_i = i.rd;
        id_regwrite_i = i.rw; id_memread_i = i.mr; flush_i = fl; rst_i = rs;
        @(negedge clk);
        c    = hist[hist.size()-1];
        e_st = needs_stall(i);
        e_fa = source_of(c.rs);
        e_fb = source_of(c.rt);
`ifdef FWD_STALL_CNT_EN
        e_cnt = cnt_model;
`else
        e_cnt = 32'd0;
`endif
        chk({tag, ".stall"}, 32'(stall_o), 32'(e_st));
        chk({tag, ".fwd_a"}, 32'(fwd_a_o), 32'(e_fa));
        chk({tag, ".fwd_b"}, 32'(fwd_b_o), 32'(e_fb));
        chk({tag, ".cnt"}, stall_cnt_o, e_cnt);
        if (use_k) begin
            chk({tag, ".k_stall"}, 32'(stall_o), 32'(k_st));
            chk({tag, ".k_fwd_a"}, 32'(fwd_a_o), 32'(k_fa));
            chk({tag, ".k_fwd_b"}, 32'(fwd_b_o), 32'(k_fb));
        end
        @(posedge clk);
        if (rs) begin
            model_reset();
        end else begin
            ins_t ent = i;
            ent.vld = i.vld && !e_st && !fl;
            hist.push_back(ent);
            void'(hist.pop_front());
            if (e_st && cnt_model != 32'hFFFF_FFFF) cnt_model++;
        end
        st_out = e_st;
        #1;
    endtask

    initial begin
        logic st;
        ins_t cur;
        rst_i = 1'b1; flush_i = 1'b0; id_valid_i = 1'b0;
        id_rs_i = '0; id_rt_i = '0; id_rd_i = '0; id_regwrite_i = 1'b0; id_memread_i = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;

        // first cycle after reset
        step(NOP, 0, 0, "post_rst", 1, 0, 2'b00, 2'b00, st);

        // 1: add r3 -> sub r4,r3,r1
        step(mk(1, 2, 3, 1, 0), 0, 0, "t1_add", 0, 0, 0, 0, st);
        step(mk(3, 1, 4, 1, 0), 0, 0, "t1_sub", 0, 0, 0, 0, st);
        step(NOP, 0, 0, "t1_ex", 1, 0, 2'b10, 2'b00, st);

        // 2: add r3; nop; or r5,r1,r3 -> 01; then add r3; add r3; use r3 -> 10
        step(mk(1, 2, 3, 1, 0), 0, 0, "t2_add", 0, 0, 0, 0, st);
        step(NOP, 0, 0, "t2_nop", 0, 0, 0, 0, st);
        step(mk(1, 3, 5, 1, 0), 0, 0, "t2_or", 0, 0, 0, 0, st);
        step(NOP, 0, 0, "t2_ex_or", 1, 0, 2'b00, 2'b01, st);
        step(mk(1, 2, 3, 1, 0), 0, 0, "t2_add1", 0, 0, 0, 0, st);
        step(mk(1, 2, 3, 1, 0), 0, 0, "t2_add2", 0, 0, 0, 0, st);
        step(mk(3, 3, 4, 1, 0), 0, 0, "t2_use", 0, 0, 0, 0, st);
        step(NOP, 0, 0, "t2_ex_pri", 1, 0, 2'b10, 2'b10, st);

        // 3: lw r2; add r6,r2,r2 -> one stall, then 01/01
        step(mk(1, 0, 2, 1, 1), 0, 0, "t3_lw", 0, 0, 0, 0, st);
        step(mk(2, 2, 6, 1, 0), 0, 0, "t3_use_stall", 1, 1, 2'b00, 2'b00, st);
        step(mk(2, 2, 6, 1, 0), 0, 0, "t3_use_held", 1, 0, 2'b00, 2'b00, st);
        step(NOP, 0, 0, "t3_ex", 1, 0, 2'b01, 2'b01, st);

        // 4: writes to r0 are never forwarded or stalled on
        step(mk(1, 1, 0, 1, 0), 0, 0, "t4_add_r0", 0, 0, 0, 0, st);
        step(mk(0, 0, 7, 1, 0), 0, 0, "t4_sub", 0, 0, 0, 0, st);
        step(NOP, 0, 0, "t4_ex", 1, 0, 2'b00, 2'b00, st);
        step(mk(1, 0, 0, 1, 1), 0, 0, "t4_lw_r0", 0, 0, 0, 0, st);
        step(mk(0, 0, 8, 1, 0), 0, 0, "t4_use_r0", 1, 0, 2'b00, 2'b00, st);

        // 5: flush with a load-use pair: stall still reported, EX gets a bubble
        step(mk(1, 0, 2, 1, 1), 0, 0, "t5_lw", 0, 0, 0, 0, st);
        step(mk(2, 2, 6, 1, 0), 1, 0, "t5_flush", 1, 1, 2'b00, 2'b00, st);
        step(NOP, 0, 0, "t5_after", 1, 0, 2'b00, 2'b00, st);

        // 6: reset while lw in MEM, then three load-use pairs, then reset again
        step(mk(1, 0, 2, 1, 1), 0, 0, "t6_lw", 0, 0, 0, 0, st);
        step(NOP, 0, 0, "t6_lw_ex", 0, 0, 0, 0, st);
        step(NOP, 0, 1, "t6_rst", 0, 0, 0, 0, st);
        step(mk(2, 2, 9, 1, 0), 0, 0, "t6_post_rst", 1, 0, 2'b00, 2'b00, st);
        chk("t6_cnt_zero", stall_cnt_o, 32'd0);
        for (int p = 0; p < 3; p++) begin
            step(mk(1, 0, 5'(10 + p), 1, 1), 0, 0, "t6_lw_n", 0, 0, 0, 0, st);
            step(mk(5'(10 + p), 1, 20, 1, 0), 0, 0, "t6_use_n", 1, 1, 2'b00, 2'b00, st);
            step(mk(5'(10 + p), 1, 20, 1, 0), 0, 0, "t6_held_n", 1, 0, 2'b00, 2'b00, st);
        end
`ifdef FWD_STALL_CNT_EN
        chk("t6_cnt_three", stall_cnt_o, 32'd3);
`else
        chk("t6_cnt_tied", stall_cnt_o, 32'd0);
`endif
        step(NOP, 0, 1, "t6_rst2", 0, 0, 0, 0, st);
        chk("t6_cnt_cleared", stall_cnt_o, 32'd0);

        // Random streams over a small register set; held in ID while stalled.
        cur = NOP;
        st  = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic fl, rs;
            if (!st) begin
                cur.vld = ($urandom_range(0, 7) != 0);
                cur.rs  = 5'($urandom_range(0, 3));
                cur.rt  = 5'($urandom_range(0, 3));
                cur.rd  = 5'($urandom_range(0, 3));
                cur.rw  = ($urandom_range(0, 3) != 0);
                cur.mr  = ($urandom_range(0, 2) == 0);
            end
            fl = ($urandom_range(0, 9) == 0);
            rs = ($urandom_range(0, 59) == 0);
            step(cur, fl, rs, "rand", 0, 0, 0, 0, st);
            if (fl || rs) st = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
